mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Round-robin arbiter that shares the single memory-interface command bus between up to NREQ requesters, such as the crypto cores and control logic. It grants one requester at a time and forwards that requester's byte stream onto the memory bus valid/ready channel. It holds the grant until the memory side completes the transaction with an ACK handshake, then rotates priority. An optional timeout watchdog releases a grant whose ACK never arrives.

## Interface
Parameters:
- NREQ, 3: number of requesters, 2..4.
- TIMEOUT_CYCLES, 1024: WAIT_ACK watchdog limit (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester byte valid.
- req_data  input  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NREQ  marks the final byte of requester i's command frame.
- req_ready  output  NREQ  per-requester byte accepted.
- mem_valid  output  1  byte valid toward memory bus (drives VALID_IN).
- mem_data  output  8  byte toward memory bus (drives DATA_IN).
- mem_ready  input  1  memory bus ready (from READY_IN).
- ack_valid  input  1  memory ACK_VALID, observed only.
- ack_ready  input  1  bus ACK_READY, observed only.
- grant_id  output  2  index of the current or last granted requester.
- busy  output  1  high in XFER or WAIT_ACK.
- timeout_err  output  1  sticky watchdog flag.
- err_clr  input  1  synchronous clear of timeout_err.

## Operation
States:
- IDLE: no grant.
  - If any req_valid is high, pick the first requester with valid asserted, searching from rr_ptr upward with wrap modulo NREQ.
  - Register that index into grant_id and go to XFER.
- XFER: forwarding is combinational from the granted requester g.
  - mem_valid = req_valid[g], mem_data = req_data[g], req_ready[g] = mem_ready.
  - All other req_ready bits are 0.
  - A transfer is mem_valid & mem_ready. A transfer with req_last[g] set goes to WAIT_ACK.
- WAIT_ACK:
  - mem_valid = 0 and all req_ready = 0.
  - On ack_valid & ack_ready: go to IDLE and set rr_ptr = (g+1) mod NREQ.
- Requesters not granted are stalled; the arbiter never drops their bytes.
- req_valid of the granted requester may deassert mid-frame; the arbiter waits in XFER with no limit.
- An ACK handshake seen in IDLE or XFER is ignored.
- A timeout_err that sets while err_clr is asserted in the same cycle: set wins.
- Single requester, NREQ=1 behaviour: not supported (NREQ ≥ 2).

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, req_ready=0, mem_valid=0, mem_data=0, busy=0, timeout_err=0, watchdog counter=0.
- Reset asserted mid-frame aborts immediately. Requesters must restart the frame.
- Grant latency: req_valid high in IDLE at cycle n → XFER at n+1 → first byte may transfer at n+1.
- Throughput in XFER: one byte per cycle while both sides are ready.
- Release: ACK handshake at cycle m → IDLE at m+1 → next grant at m+2. Minimum gap between frames is 2 cycles.
- Last-byte transfer at cycle k → WAIT_ACK at k+1. An ACK at k+1 is legal.
- Simultaneous requests resolve by rotating priority only. Each requester is granted at most once per NREQ grants when all are pending.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_ACK and increments each cycle in WAIT_ACK.
  - When it reaches TIMEOUT_CYCLES-1 without an ACK: set timeout_err, go to IDLE, advance rr_ptr as for a normal release.
  - timeout_err clears only on err_clr or reset.
- MEM_ARB_TIMEOUT_EN undefined:
  - There is no counter; WAIT_ACK waits indefinitely.
  - timeout_err is tied to 0 and err_clr is ignored.

## Test plan
- Single frame: requester 1 sends 0xA5, 0x3C (last), mem_ready=1.
  - Expect grant_id=1 one cycle after valid, then mem_data 0xA5, 0x3C on consecutive cycles, busy high.
  - ACK handshake → busy low the next cycle.
- Round-robin: all three requesters hold a 1-byte frame continuously.
  - Grants follow 0,1,2,0. Two idle cycles separate each frame from the next.
- Backpressure: mem_ready toggles 1,0,0,1 during a 4-byte frame from requester 2.
  - Every byte appears exactly once, in order. req_ready[2] follows mem_ready, and other req_ready stay 0.
- Timeout (macro on, TIMEOUT_CYCLES=16): no ACK after the last byte.
  - timeout_err rises after 16 WAIT_ACK cycles, arbiter returns to IDLE, next requester is granted.
  - Pulsing err_clr clears the flag.
- Reset mid-frame: assert rst_n=0 after 2 of 4 bytes.
  - All outputs reach reset values immediately, and grant_id=0 after release.
  - Requester 0 has priority on the next grant.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory command bus among NREQ byte-stream requesters.
// Optional ACK watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_bus_arbiter #(
    parameter int NREQ           = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic                mem_valid,
    output logic [7:0]          mem_data,
    input  logic                mem_ready,
    input  logic                ack_valid,
    input  logic                ack_ready,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic                timeout_err,
    input  logic                err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XFER     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] rr_ptr_reg, rr_ptr_next;
    logic [1:0] grant_reg, grant_next;

    logic [7:0]      data_arr [NREQ];
    logic [2:0]      cand_sum [NREQ];
    logic [1:0]      cand_idx [NREQ];
    logic [NREQ-1:0] cand_valid;
    logic            pick_found;
    logic [1:0]      pick_idx;

    logic            sel_valid;
    logic            sel_last;
    logic [7:0]      sel_data;
    logic            ack_hs;
    logic            wd_expired;

    assign ack_hs = ack_valid & ack_ready;

    // Candidate k is the k-th requester in priority order, starting at rr_ptr.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign data_arr[gi]   = req_data[8*gi +: 8];
        assign cand_sum[gi]   = {1'b0, rr_ptr_reg} + 3'(gi);
        assign cand_idx[gi]   = (cand_sum[gi] >= 3'(NREQ)) ? 2'(cand_sum[gi] - 3'(NREQ))
                                                           : cand_sum[gi][1:0];
        assign cand_valid[gi] = req_valid[cand_idx[gi]];
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_reg == 2'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = data_arr[i];
            end
        end
    end

    function automatic logic [1:0] next_ptr(input logic [1:0] g);
        return (int'(g) == NREQ - 1) ? 2'd0 : g + 2'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            rr_ptr_reg <= 2'd0;
            grant_reg  <= 2'd0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            grant_reg  <= grant_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_next  = grant_reg;
        req_ready   = '0;
        mem_valid   = 1'b0;
        mem_data    = 8'd0;
        unique case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_next = pick_idx;
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                mem_valid = sel_valid;
                mem_data  = sel_data;
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = mem_ready && (grant_reg == 2'(i));
                end
                if (sel_valid && mem_ready && sel_last) begin
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // A lost ACK is released exactly like a real one so priority still rotates.
                if (ack_hs || wd_expired) begin
                    state_next  = ST_IDLE;
                    rr_ptr_next = next_ptr(grant_reg);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign grant_id = grant_reg;
    assign busy     = (state_reg != ST_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_err_reg;
    logic            timeout_set;

    assign wd_expired  = (state_reg == ST_WAIT_ACK) && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout_set = wd_expired && !ack_hs;

    // Counter sits at zero outside WAIT_ACK, so it restarts on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT_ACK) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end else begin
                wd_cnt_reg <= '0;
            end
            if (timeout_set) begin
                timeout_err_reg <= 1'b1;
            end else if (err_clr) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign wd_expired     = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random requester streams, a frame-level
// arbitration model, and directed watchdog / mid-frame reset scenarios.
module tb_mem_bus_arbiter;

    localparam int NREQ = 3;
    localparam int TO   = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_ready;
    logic                mem_valid;
    logic [7:0]          mem_data;
    logic                mem_ready;
    logic                ack_valid;
    logic                ack_ready;
    logic [1:0]          grant_id;
    logic                busy;
    logic                timeout_err;
    logic                err_clr;

    mem_bus_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
        .ack_valid(ack_valid), .ack_ready(ack_ready),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: per-requester queue of {last, byte} pushed by the drivers.
    logic [8:0] exp_q [NREQ][$];
    int         grants[$];
    int         grant_cyc[$];
    logic       took [NREQ];

    bit mon_en  = 0;
    bit stop    = 0;
    bit rr_mode = 0;
    int m_phase = 0;   // 0 no grant, 1 forwarding, 2 awaiting ACK
    int m_ptr   = 0;
    int m_g     = 0;
    int m_wcnt  = 0;
    bit m_err   = 0;
    int cyc     = 0;

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic monitor_loop();
        logic [8:0] e;
        bit hs;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) took[i] = req_valid[i] & req_ready[i];
            if (mon_en) begin
                hs = ack_valid & ack_ready;
                chk(timeout_err == m_err, "timeout_err", int'(timeout_err), int'(m_err));
                case (m_phase)
                    0: begin
                        chk(!busy && !mem_valid && req_ready == '0, "idle_outputs",
                            int'({busy, mem_valid, req_ready}), 0);
                        if (req_valid != '0) begin
                            m_g = pick(req_valid);
                            m_phase = 1;
                            grants.push_back(m_g);
                            grant_cyc.push_back(cyc);
                        end
                    end
                    1: begin
                        chk(busy && int'(grant_id) == m_g, "grant_id", int'(grant_id), m_g);
                        chk(mem_valid == req_valid[m_g], "mem_valid", int'(mem_valid), int'(req_valid[m_g]));
                        chk(int'(req_ready) == (mem_ready ? (1 << m_g) : 0), "req_ready",
                            int'(req_ready), mem_ready ? (1 << m_g) : 0);
                        if (mem_valid && mem_ready) begin
                            if (exp_q[m_g].size() == 0) begin
                                chk(0, "unexpected_byte", int'(mem_data), 0);
                            end else begin
                                e = exp_q[m_g].pop_front();
                                $display("xfer req=%0d data=%02h last=%0d", m_g, mem_data, e[8]);
                                chk(mem_data == e[7:0], "mem_data", int'(mem_data), int'(e[7:0]));
                                if (e[8]) begin
                                    m_phase = 2;
                                    m_wcnt  = 0;
                                end
                            end
                        end
                    end
                    default: begin
                        chk(busy && !mem_valid && req_ready == '0, "wait_outputs",
                            int'({busy, mem_valid, req_ready}), 16);
                        if (hs) begin
                            m_phase = 0;
                            m_ptr   = (m_g + 1) % NREQ;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        else if (m_wcnt == TO - 1) begin
                            m_phase = 0;
                            m_ptr   = (m_g + 1) % NREQ;
                            m_err   = 1;
                        end else begin
                            m_wcnt++;
                        end
`endif
                    end
                endcase
            end
        end
    endtask

    task automatic run_req(input int i, input int nfr, input int gap, input int maxlen);
        int len;
        int t;
        logic [7:0] d;
        logic l;
        for (int f = 0; f < nfr; f++) begin
            len = $urandom_range(1, maxlen);
            for (int b = 0; b < len; b++) begin
                d = 8'($urandom);
                l = (b == len - 1);
                exp_q[i].push_back({l, d});
                req_valid[i] = 1'b0;
                while ($urandom_range(0, 99) < gap) begin
                    @(posedge clk); #1;
                end
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = d;
                req_last[i] = l;
                t = 0;
                do begin
                    @(posedge clk); #1;
                    t++;
                end while (!took[i] && t < 2000);
                if (!took[i]) begin
                    chk(0, "accept_timeout", i, 1);
                    req_valid[i] = 1'b0;
                    return;
                end
            end
        end
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
    endtask

    task automatic ack_proc();
        while (!stop) begin
            @(posedge clk); #1;
            if (rr_mode) begin
                ack_valid = 1'b1;
                ack_ready = 1'b1;
                mem_ready = 1'b1;
            end else begin
                ack_valid = 1'($urandom_range(0, 1));
                ack_ready = 1'($urandom_range(0, 1));
                mem_ready = ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 3000 && m_phase != 0; t++) @(posedge clk);
        chk(m_phase == 0, "drain_timeout", m_phase, 0);
    endtask

    task automatic run_phase(input int nfr, input int gap, input int maxlen);
        stop = 0;
        fork
            begin
                fork
                    run_req(0, nfr, gap, maxlen);
                    run_req(1, nfr, gap, maxlen);
                    run_req(2, nfr, gap, maxlen);
                join
                wait_idle();
                stop = 1;
            end
            ack_proc();
        join
    endtask

    task automatic send_manual(input int i, input logic [7:0] d, input logic l);
        int t;
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = d;
        req_last[i] = l;
        t = 0;
        @(negedge clk);
        while (!req_ready[i] && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk(req_ready[i] == 1'b1, "manual_accept", int'(req_ready[i]), 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
    endtask

    initial begin
        int rr_start;
        int cnt;
        bit distinct;
        rst_n = 0; req_valid = '0; req_data = '0; req_last = '0;
        mem_ready = 0; ack_valid = 0; ack_ready = 0; err_clr = 0;
        for (int i = 0; i < NREQ; i++) took[i] = 1'b0;
        fork monitor_loop(); join_none

        // Reset values
        #12;
        chk(busy == 0, "rst_busy", int'(busy), 0);
        chk(mem_valid == 0, "rst_mem_valid", int'(mem_valid), 0);
        chk(req_ready == '0, "rst_req_ready", int'(req_ready), 0);
        chk(mem_data == 8'd0, "rst_mem_data", int'(mem_data), 0);
        chk(grant_id == 2'd0, "rst_grant_id", int'(grant_id), 0);
        chk(timeout_err == 0, "rst_timeout_err", int'(timeout_err), 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1; mon_en = 1;

        // Random multi-byte frames with valid gaps, backpressure and random ACKs
        rr_mode = 0;
        run_phase(8, 30, 4);

        // All three continuously pending with single-byte frames
        rr_mode  = 1;
        rr_start = grants.size();
        run_phase(4, 0, 1);
        for (int j = rr_start; j + 2 < grants.size(); j++) begin
            distinct = (grants[j] != grants[j+1]) && (grants[j] != grants[j+2]) && (grants[j+1] != grants[j+2]);
            chk(distinct, "rr_fairness", grants[j] * 100 + grants[j+1] * 10 + grants[j+2], 12);
        end
        for (int j = rr_start + 1; j < grants.size(); j++) begin
            chk(grant_cyc[j] - grant_cyc[j-1] == 3, "rr_frame_gap", grant_cyc[j] - grant_cyc[j-1], 3);
        end
        for (int i = 0; i < NREQ; i++) chk(exp_q[i].size() == 0, "leftover_bytes", exp_q[i].size(), 0);
        mon_en = 0;

        // Missing ACK
        @(posedge clk); #1;
        ack_valid = 0; ack_ready = 0; mem_ready = 1;
        send_manual(0, 8'h5A, 1'b1);
        req_valid = '1; req_last = '0; mem_ready = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk(cnt == TO, "wait_ack_cycles", cnt, TO);
        chk(timeout_err == 1, "timeout_set", int'(timeout_err), 1);
        @(negedge clk);
        chk(busy && grant_id == 2'd1, "grant_after_timeout", int'(grant_id), 1);
        @(posedge clk); #1; err_clr = 1;
        @(posedge clk); #1; err_clr = 0;
        @(negedge clk);
        chk(timeout_err == 0, "err_clr", int'(timeout_err), 0);
`else
        cnt = 0;
        repeat (40) @(negedge clk);
        chk(busy == 1, "wait_forever_busy", int'(busy), 1);
        chk(grant_id == 2'd0, "wait_forever_grant", int'(grant_id), 0);
        chk(timeout_err == 0, "no_timeout", int'(timeout_err), 0);
        @(posedge clk); #1; err_clr = 1;
        @(posedge clk); #1; err_clr = 0;
        @(negedge clk);
        chk(timeout_err == 0, "err_clr_ignored", int'(timeout_err), 0);
`endif

        // Reset mid-frame
        @(posedge clk); #1;
        rst_n = 0; req_valid = '0; req_last = '0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1; mem_ready = 1;
        send_manual(2, 8'h11, 1'b0);
        send_manual(2, 8'h22, 1'b0);
        req_valid[2] = 1'b1; req_data[23:16] = 8'h33;
        #2; rst_n = 0; #1;
        chk(busy == 0, "midrst_busy", int'(busy), 0);
        chk(mem_valid == 0, "midrst_mem_valid", int'(mem_valid), 0);
        chk(req_ready == '0, "midrst_req_ready", int'(req_ready), 0);
        chk(mem_data == 8'd0, "midrst_mem_data", int'(mem_data), 0);
        chk(grant_id == 2'd0, "midrst_grant_id", int'(grant_id), 0);
        @(negedge clk);
        rst_n = 1;
        req_valid[0] = 1'b1; req_data[7:0] = 8'h44; req_last[0] = 1'b1;
        chk(grant_id == 2'd0, "release_grant_id", int'(grant_id), 0);
        @(negedge clk);
        chk(busy && grant_id == 2'd0, "post_reset_priority", int'(grant_id), 0);
        chk(mem_data == 8'h44, "post_reset_data", int'(mem_data), 8'h44);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
